// File: rtl/io_dsp_path_if.sv
// Sample, config and DAC-side signals of the two-channel ADC-to-DAC processing stage.
// master = the block feeding samples and config, slave = io_dsp_path.
interface io_dsp_path_if #(
    parameter int ADC_W  = 14,
    parameter int DAC_W  = 16,
    parameter int GAIN_W = 16
);
    logic              enable;
    logic [ADC_W-1:0]  adc_a;
    logic [ADC_W-1:0]  adc_b;
    logic              cfg_wr;
    logic [1:0]        cfg_addr;
    logic [GAIN_W-1:0] cfg_data;
    logic              cfg_ack;
    logic [DAC_W-1:0]  dac_a;
    logic [DAC_W-1:0]  dac_b;
    logic              valid_out;
    logic              sat_a;
    logic              sat_b;
    logic [15:0]       sat_count;

    modport master (
        output enable, adc_a, adc_b, cfg_wr, cfg_addr, cfg_data,
        input  cfg_ack, dac_a, dac_b, valid_out, sat_a, sat_b, sat_count
    );

    modport slave (
        input  enable, adc_a, adc_b, cfg_wr, cfg_addr, cfg_data,
        output cfg_ack, dac_a, dac_b, valid_out, sat_a, sat_b, sat_count
    );
endinterface

// File: rtl/io_dsp_path.sv
// Two-channel ADC->DAC sample path: optional DC removal, Q2.14 gain, round, saturate.
// Four registered stages per lane; config registers and saturation counter are shared.
module io_dsp_lane #(
    parameter int ADC_W  = 14,
    parameter int DAC_W  = 16,
    parameter int GAIN_W = 16,
    parameter int DC_K   = 12
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              track,
    input  logic [ADC_W-1:0]  adc,
    input  logic [GAIN_W-1:0] gain,
    output logic [DAC_W-1:0]  dac,
    output logic              sat
);
    localparam int ACC_W = ADC_W + DC_K;
    localparam int Y_W   = ADC_W + 1;
    localparam int P_W   = Y_W + GAIN_W;
    // Q2.14 gain leaves 14 fraction bits; the 2-bit widening to DAC_W keeps 2 of them.
    localparam int SHIFT = GAIN_W - 2 - (DAC_W - ADC_W);
    localparam logic signed [P_W-1:0] HALF = P_W'(1) << (SHIFT - 1);
    localparam logic signed [P_W-1:0] DMAX = P_W'((1 << (DAC_W - 1)) - 1);
    localparam logic signed [P_W-1:0] DMIN = ~DMAX;

    logic signed [ADC_W-1:0] s0;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sh;
    logic signed [ADC_W-1:0] dc;
    logic signed [Y_W-1:0]   s1;
    logic signed [P_W-1:0]   s2;
    logic signed [P_W-1:0]   y_x;
    logic signed [P_W-1:0]   g_x;
    logic signed [P_W-1:0]   rsum;
    logic signed [P_W-1:0]   rsh;
    logic                    sat_hi;
    logic                    sat_lo;

    assign acc_sh = acc >>> DC_K;
    assign dc     = track ? acc_sh[ADC_W-1:0] : '0;
    assign y_x    = {{GAIN_W{s1[Y_W-1]}}, s1};
    assign g_x    = {{Y_W{gain[GAIN_W-1]}}, gain};
    assign rsum   = s2 + HALF;
    assign rsh    = rsum >>> SHIFT;
    assign sat_hi = rsh > DMAX;
    assign sat_lo = rsh < DMIN;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s0  <= '0;
            acc <= '0;
            s1  <= '0;
            s2  <= '0;
            dac <= '0;
            sat <= 1'b0;
        end else begin
            s0 <= enable ? adc : '0;
            if (!track) acc <= '0;
            else        acc <= acc + {{DC_K{s0[ADC_W-1]}}, s0} - acc_sh;
            s1 <= {s0[ADC_W-1], s0} - {dc[ADC_W-1], dc};
            s2 <= y_x * g_x;
            if (sat_hi)      dac <= {1'b0, {(DAC_W-1){1'b1}}};
            else if (sat_lo) dac <= {1'b1, {(DAC_W-1){1'b0}}};
            else             dac <= rsh[DAC_W-1:0];
            sat <= sat_hi | sat_lo;
        end
    end
endmodule

module io_dsp_path #(
    parameter int ADC_W  = 14,
    parameter int DAC_W  = 16,
    parameter int GAIN_W = 16,
    parameter int DC_K   = 12
) (
    input  logic         clk,
    input  logic         n_rst,
    io_dsp_path_if.slave bus
);
    localparam int NUM_LANES = 2;
    localparam int STAGES    = 4;
    localparam int CNT_W     = 16;
    localparam int CLR_BIT   = 2;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << (GAIN_W - 2);

    logic [NUM_LANES-1:0][ADC_W-1:0]  adc;
    logic [NUM_LANES-1:0][GAIN_W-1:0] gain;
    logic [NUM_LANES-1:0][DAC_W-1:0]  dac;
    logic [NUM_LANES-1:0]             sat;
    logic [NUM_LANES-1:0]             track;
    logic [STAGES:1]                  vld_pipe;
    logic                             cfg_ack;
    logic [CNT_W-1:0]                 sat_count;
    logic                             clr_sat;

    assign adc     = {bus.adc_b, bus.adc_a};
    // Clear is a write side effect only; the bit is never stored in ctrl.
    assign clr_sat = bus.cfg_wr && (bus.cfg_addr == 2'd2) && bus.cfg_data[CLR_BIT];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            gain      <= {NUM_LANES{UNITY}};
            track     <= '0;
            cfg_ack   <= 1'b0;
            sat_count <= '0;
            vld_pipe  <= '0;
        end else begin
            cfg_ack  <= bus.cfg_wr;
            vld_pipe <= {vld_pipe[STAGES-1:1], bus.enable};
            if (bus.cfg_wr) begin
                case (bus.cfg_addr)
                    2'd0:    gain[0] <= bus.cfg_data;
                    2'd1:    gain[1] <= bus.cfg_data;
                    2'd2:    track   <= bus.cfg_data[NUM_LANES-1:0];
                    default: ;
                endcase
            end
            if (clr_sat)
                sat_count <= '0;
            else if ((|sat) && (sat_count != '1))
                sat_count <= sat_count + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        io_dsp_lane #(
            .ADC_W (ADC_W),
            .DAC_W (DAC_W),
            .GAIN_W(GAIN_W),
            .DC_K  (DC_K)
        ) u_lane (
            .clk   (clk),
            .n_rst (n_rst),
            .enable(bus.enable),
            .track (track[i]),
            .adc   (adc[i]),
            .gain  (gain[i]),
            .dac   (dac[i]),
            .sat   (sat[i])
        );
    end

    assign bus.dac_a     = dac[0];
    assign bus.dac_b     = dac[1];
    assign bus.sat_a     = sat[0];
    assign bus.sat_b     = sat[1];
    assign bus.valid_out = vld_pipe[STAGES];
    assign bus.cfg_ack   = cfg_ack;
    assign bus.sat_count = sat_count;
endmodule

// File: tb/tb_io_dsp_path.sv
// Bench for io_dsp_path: scoreboarded sample stream plus directed config, DC, saturation
// counter and mid-stream reset checks.
module tb_io_dsp_path;
    logic clk = 1'b0;
    logic n_rst;
    always #10 clk = ~clk;

    io_dsp_path_if bus();
    io_dsp_path dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] sb[$];
    logic [33:0] exp_e;
    bit          sb_on = 1'b0;
    int          sh_gain_a, sh_gain_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // {sat, dac} for one sample through a lane with DC removal off
    function automatic logic [16:0] model(input int adc, input int gain);
        logic [13:0] a14;
        logic [15:0] g16;
        longint      p, r;
        a14 = adc[13:0];
        g16 = gain[15:0];
        p = longint'($signed(a14)) * longint'($signed(g16));
        r = (p + 2048) >>> 12;
        if (r > 32767)  return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit en, input int a, input int b, input bit wr, input int addr, input int data);
        bus.enable   = en;
        bus.adc_a    = a[13:0];
        bus.adc_b    = b[13:0];
        bus.cfg_wr   = wr;
        bus.cfg_addr = addr[1:0];
        bus.cfg_data = data[15:0];
        if (en && sb_on) sb.push_back({model(b, sh_gain_b), model(a, sh_gain_a)});
        if (wr && addr == 0) sh_gain_a = data;
        if (wr && addr == 1) sh_gain_b = data;
        tick();
    endtask

    task automatic cfg(input int addr, input int data);
        step(bus.enable, int'(bus.adc_a), int'(bus.adc_b), 1'b1, addr, data);
        check("cfg_ack", 32'(bus.cfg_ack), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (sb_on && bus.valid_out) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
                exp_e = sb.pop_front();
                check("ch_a", 32'({bus.sat_a, bus.dac_a}), 32'(exp_e[16:0]));
                check("ch_b", 32'({bus.sat_b, bus.dac_b}), 32'(exp_e[33:17]));
            end
        end
    end

    logic [15:0] c1, prev;
    int          viol, settled, sat_steps;

    initial begin
        n_rst = 1'b0;
        bus.enable = 1'b0; bus.adc_a = '0; bus.adc_b = '0;
        bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        sh_gain_a = 'h4000; sh_gain_b = 'h4000;
        repeat (2) tick();
        check("rst_dac", {bus.dac_a, bus.dac_b}, 0);
        check("rst_flags", 32'({bus.valid_out, bus.sat_a, bus.sat_b, bus.cfg_ack}), 0);
        check("rst_cnt", 32'(bus.sat_count), 0);
        n_rst = 1'b1;
        tick();

        // unity gain, latency of valid_out
        sb_on = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 'h1000, 'h0100, 1'b0, 0, 0);
            check("ack_idle", 32'(bus.cfg_ack), 0);
            if (i == 3) check("vld_early", 32'(bus.valid_out), 0);
            if (i == 4) check("vld_lat", 32'(bus.valid_out), 1);
        end
        idle(6);
        check("drain_dac", 32'(bus.dac_a), 0);
        check("drain_vld", 32'(bus.valid_out), 0);
        check("sb_empty", sb.size(), 0);

        // back-to-back writes, reserved address ignored
        cfg(0, 'h2000);
        cfg(1, 'hE000);
        cfg(3, 'h0007);
        idle(1);
        check("ack_drop", 32'(bus.cfg_ack), 0);
        for (int i = 0; i < 24; i++) step(1'b1, int'($urandom), int'($urandom), 1'b0, 0, 0);
        idle(6);
        check("sb_empty", sb.size(), 0);

        // random gains
        cfg(0, int'($urandom));
        cfg(1, int'($urandom));
        idle(1);
        for (int i = 0; i < 24; i++) step(1'b1, int'($urandom), int'($urandom), 1'b0, 0, 0);
        idle(6);
        check("sb_empty", sb.size(), 0);

        // positive saturation and counter rate
        cfg(0, 'h7FFF);
        cfg(1, 'h4000);
        idle(1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b1, 'h1FFF, 'h0800, 1'b0, 0, 0);
            if (i == 6) c1 = bus.sat_count;
            if (i == 9) check("sat_rate", 32'(bus.sat_count - c1), 3);
        end
        idle(6);
        check("sb_empty", sb.size(), 0);

        // full-scale negative without saturation
        cfg(0, 'h4000);
        idle(1);
        for (int i = 0; i < 6; i++) step(1'b1, 'h2000, 'h1FFF, 1'b0, 0, 0);
        idle(6);
        check("sb_empty", sb.size(), 0);

        // clear vs saturation, then long saturation on B with DC tracking on A
        sb_on = 1'b0;
        cfg(1, 'hC000);
        for (int i = 0; i < 6; i++) step(1'b1, 1000, 'h2000, 1'b0, 0, 0);
        check("sat_b", 32'({bus.sat_b, bus.dac_b}), 32'(model('h2000, 'hC000)));
        step(1'b1, 1000, 'h2000, 1'b1, 2, 'h0004);
        check("clr_cnt", 32'(bus.sat_count), 0);
        check("clr_ack", 32'(bus.cfg_ack), 1);
        step(1'b1, 1000, 'h2000, 1'b0, 0, 0);
        check("clr_ack_drop", 32'(bus.cfg_ack), 0);
        check("cnt_resume", 32'(bus.sat_count), 1);
        sat_steps = 2;

        step(1'b1, 1000, 'h2000, 1'b1, 2, 'h0001);
        sat_steps++;
        prev = bus.dac_a; viol = 0; settled = 0;
        for (int i = 0; i < 8 * 4096 && settled == 0; i++) begin
            step(1'b1, 1000, 'h2000, 1'b0, 0, 0);
            sat_steps++;
            if ($signed(bus.dac_a) > $signed(prev)) viol++;
            prev = bus.dac_a;
            if ($signed(bus.dac_a) <= 8 && $signed(bus.dac_a) >= -8) settled = 1;
        end
        check("dc_settle", settled, 1);
        check("dc_mono", viol, 0);
        step(1'b1, 1000, 'h2000, 1'b1, 2, 'h0000);
        sat_steps++;
        repeat (4) begin step(1'b1, 1000, 'h2000, 1'b0, 0, 0); sat_steps++; end
        check("dc_off", 32'(bus.dac_a), 4000);
        while (sat_steps < 70000) begin
            step(1'b1, 1000, 'h2000, 1'b0, 0, 0);
            sat_steps++;
        end
        check("cnt_stick", 32'(bus.sat_count), 'hFFFF);
        repeat (3) step(1'b1, 1000, 'h2000, 1'b0, 0, 0);
        check("cnt_nowrap", 32'(bus.sat_count), 'hFFFF);
        check("sat_b_long", 32'({bus.sat_b, bus.dac_b}), 32'(model('h2000, 'hC000)));

        // short asynchronous reset pulse mid-stream
        #2 n_rst = 1'b0;
        #1;
        check("arst_dac", {bus.dac_a, bus.dac_b}, 0);
        check("arst_flags", 32'({bus.valid_out, bus.sat_a, bus.sat_b, bus.cfg_ack}), 0);
        check("arst_cnt", 32'(bus.sat_count), 0);
        #1 n_rst = 1'b1;
        sh_gain_a = 'h4000; sh_gain_b = 'h4000;
        sb.delete();
        idle(3);
        check("vld_post_rst", 32'(bus.valid_out), 0);
        sb_on = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 'h1000, 'h0800, 1'b0, 0, 0);
            if (i == 3) check("vld_early2", 32'(bus.valid_out), 0);
            if (i == 4) check("vld_lat2", 32'(bus.valid_out), 1);
        end
        idle(6);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
